// File: rtl/vga_timing_gen.sv
// VGA timing generator: hsync/vsync/active plus visible x,y, line/frame start.
// Ports: dclk, clr_n (async low), pix_en strobe in; hsync, vsync, active, x, y,
//   line_start, frame_start, frame_cnt out. frame_cnt counts completed frames
//   only when VGA_TIMING_FRAMECNT_EN is defined; otherwise it is tied to 0.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] HT_M1  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] VT_M1  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HA_END = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VA_BEG = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VA_END = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0] hc, vc;
  logic [CW-1:0] hc_n, vc_n;
  logic          wrap;

  logic          hs_d, vs_d, act_d, ls_d, fs_d;
  logic [CW-1:0] x_d, y_d;

  always_comb begin
    hc_n = hc;
    vc_n = vc;
    wrap = 1'b0;
    if (hc != HT_M1) begin
      hc_n = hc + 1'b1;
    end else if (vc != VT_M1) begin
      hc_n = '0;
      vc_n = vc + 1'b1;
    end else begin
      hc_n = '0;
      vc_n = '0;
      wrap = 1'b1;
    end
  end

  // Decode from the current (pre-advance) position; registered below.
  always_comb begin
    hs_d  = (hc < HS_END) ? HS_POL : ~HS_POL;
    vs_d  = (vc < VS_END) ? VS_POL : ~VS_POL;
    act_d = (hc >= HA_BEG) && (hc < HA_END) &&
            (vc >= VA_BEG) && (vc < VA_END);
    x_d   = '0;
    y_d   = '0;
    if (act_d) begin
      x_d = hc - HA_BEG;
      y_d = vc - VA_BEG;
    end
    ls_d  = (hc == '0);
    fs_d  = (hc == '0) && (vc == '0);
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hc          <= hc_n;
      vc          <= vc_n;
      hsync       <= hs_d;
      vsync       <= vs_d;
      active      <= act_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] fcnt_q;
  logic        wrap_q;

  // The wrap is remembered for one strobe so the count steps together
  // with the registered frame_start of the new frame.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      fcnt_q <= '0;
      wrap_q <= 1'b0;
    end else if (pix_en) begin
      wrap_q <= wrap;
      if (wrap_q) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign frame_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing and a tiny
// 8x6 configuration checked against a closed-form position model.
module tb_vga_timing_gen;

  logic dclk;
  logic d_clr, d_en;
  logic s_clr, s_en;

  logic        d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;

  logic        s_hs, s_vs, s_act, s_ls, s_fs;
  logic [3:0]  s_x, s_y;
  logic [15:0] s_fc;

  int tests;
  int fails;
  int s;

  vga_timing_gen u_def (
    .dclk(dclk), .clr_n(d_clr), .pix_en(d_en),
    .hsync(d_hs), .vsync(d_vs), .active(d_act),
    .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) u_sml (
    .dclk(dclk), .clr_n(s_clr), .pix_en(s_en),
    .hsync(s_hs), .vsync(s_vs), .active(s_act),
    .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs),
    .frame_cnt(s_fc)
  );

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int n);
    d_en = 1'b1;
    repeat (n) @(posedge dclk);
    #1;
    s += n;
  endtask

  task automatic idle(input int n);
    d_en = 1'b0;
    repeat (n) @(posedge dclk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".hs"}, 32'(d_hs), 32'd1);
    chk({tag, ".vs"}, 32'(d_vs), 32'd1);
    chk({tag, ".act"}, 32'(d_act), 32'd0);
    chk({tag, ".x"}, 32'(d_x), 32'd0);
    chk({tag, ".y"}, 32'(d_y), 32'd0);
    chk({tag, ".ls"}, 32'(d_ls), 32'd0);
    chk({tag, ".fs"}, 32'(d_fs), 32'd0);
    chk({tag, ".fc"}, 32'(d_fc), 32'd0);
  endtask

  initial begin
    int p, hc, vc;
    logic a;
    tests = 0;
    fails = 0;
    s     = 0;
    d_clr = 1'b0; d_en = 1'b0;
    s_clr = 1'b0; s_en = 1'b0;

    #12;
    chk_rst("rst");
    d_clr = 1'b1;

    strobe(1);
    chk("e1.hs", 32'(d_hs), 32'd0);
    chk("e1.vs", 32'(d_vs), 32'd0);
    chk("e1.ls", 32'(d_ls), 32'd1);
    chk("e1.fs", 32'(d_fs), 32'd1);
    chk("e1.act", 32'(d_act), 32'd0);

    strobe(1);
    chk("e2.ls", 32'(d_ls), 32'd0);
    chk("e2.fs", 32'(d_fs), 32'd0);

    strobe(96 - s);
    chk("e96.hs", 32'(d_hs), 32'd0);
    strobe(1);
    chk("e97.hs", 32'(d_hs), 32'd1);

    strobe(801 - s);
    chk("e801.ls", 32'(d_ls), 32'd1);
    chk("e801.fs", 32'(d_fs), 32'd0);
    chk("e801.vs", 32'(d_vs), 32'd0);

    strobe(1601 - s);
    chk("e1601.vs", 32'(d_vs), 32'd1);

    strobe(24944 - s);
    chk("e24944.act", 32'(d_act), 32'd0);

    idle(1);
    chk("hold0.act", 32'(d_act), 32'd0);
    strobe(1);
    chk("e24945.act", 32'(d_act), 32'd1);
    chk("e24945.x", 32'(d_x), 32'd0);
    chk("e24945.y", 32'(d_y), 32'd0);
    idle(1);
    chk("hold1.act", 32'(d_act), 32'd1);
    chk("hold1.x", 32'(d_x), 32'd0);
    strobe(1);
    chk("e24946.x", 32'(d_x), 32'd1);
    idle(3);
    chk("hold2.x", 32'(d_x), 32'd1);

    strobe(25584 - s);
    chk("e25584.x", 32'(d_x), 32'd639);
    chk("e25584.act", 32'(d_act), 32'd1);
    strobe(1);
    chk("e25585.act", 32'(d_act), 32'd0);
    chk("e25585.x", 32'(d_x), 32'd0);

    strobe(25900 - s);
    chk("e25900.x", 32'(d_x), 32'd155);
    chk("e25900.y", 32'(d_y), 32'd1);
    chk("e25900.fc", 32'(d_fc), 32'd0);

    #3 d_clr = 1'b0;
    #1;
    chk_rst("arst");
    @(posedge dclk);
    #1;
    chk_rst("arst_hold");
    d_clr = 1'b1;
    strobe(1);
    chk("rel.fs", 32'(d_fs), 32'd1);
    chk("rel.ls", 32'(d_ls), 32'd1);
    chk("rel.hs", 32'(d_hs), 32'd0);
    d_en = 1'b0;

    #2 s_clr = 1'b1;
    s_en = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(posedge dclk);
      #1;
      p  = (k - 1) % 48;
      hc = p % 8;
      vc = p / 8;
      a  = (hc >= 3) && (hc < 7) && (vc >= 2) && (vc < 5);
      chk("sml.hs", 32'(s_hs), 32'(hc < 2));
      chk("sml.vs", 32'(s_vs), 32'(vc >= 1));
      chk("sml.act", 32'(s_act), 32'(a));
      chk("sml.x", 32'(s_x), a ? 32'(hc - 3) : 32'd0);
      chk("sml.y", 32'(s_y), a ? 32'(vc - 2) : 32'd0);
      chk("sml.ls", 32'(s_ls), 32'(hc == 0));
      chk("sml.fs", 32'(s_fs), 32'(p == 0));
`ifdef VGA_TIMING_FRAMECNT_EN
      chk("sml.fc", 32'(s_fc), 32'((k - 1) / 48));
`else
      chk("sml.fc", 32'(s_fc), 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 SHALL have parameter V_BP, default 29: vertical back porch, in lines.
REQ-009 SHALL have parameter HS_POL, default 0: hsync asserted level.
REQ-010 SHALL have parameter VS_POL, default 0: vsync asserted level.
REQ-011 SHALL have parameter CW, default 10: width of counters and coordinates.
REQ-012 SHALL have port dclk, input, 1 bit: single clock, rising edge.
REQ-013 SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-014 SHALL have port pix_en, input, 1 bit: pixel strobe; the block advances only on dclk edges where it is 1.
REQ-015 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-016 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-017 SHALL have port active, output, 1 bit: current pixel is visible.
REQ-018 SHALL have port x, output, CW bits: visible column, 0..H_ACTIVE-1.
REQ-019 SHALL have port y, output, CW bits: visible row, 0..V_ACTIVE-1.
REQ-020 SHALL have port line_start, output, 1 bit: first pixel of a line.
REQ-021 SHALL have port frame_start, output, 1 bit: first pixel of a frame.
REQ-022 SHALL have port frame_cnt, output, 16 bits: completed-frame count (only with REQ-038).

Function
REQ-023 SHALL use H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOT = V_SYNC+V_BP+V_ACTIVE+V_FP; the defaults give 800 and 521.
REQ-024 SHALL order each line and each frame as: sync, back porch, active, front porch, with sync starting at counter value 0.
REQ-025 SHALL keep internal hc in 0..H_TOT-1 and vc in 0..V_TOT-1.
REQ-026 SHALL, on a pix_en edge, increment hc; at H_TOT-1, hc wraps to 0 and vc increments; at V_TOT-1 with hc at H_TOT-1, vc wraps to 0.
REQ-027 SHALL register all outputs, decoding them from the pre-advance (hc,vc) on the same pix_en edge (one-pixel latency).
REQ-028 SHALL hold every output and counter unchanged on edges where pix_en is 0; pulses therefore last exactly one pixel period.
REQ-029 SHALL drive hsync = HS_POL when hc < H_SYNC, else ~HS_POL.
REQ-030 SHALL drive vsync = VS_POL when vc < V_SYNC, else ~VS_POL.
REQ-031 SHALL drive active = 1 when H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vc < V_SYNC+V_BP+V_ACTIVE.
REQ-032 SHALL drive x = hc-(H_SYNC+H_BP) and y = vc-(V_SYNC+V_BP) while active=1, and 0 otherwise (no wrap artefacts).
REQ-033 SHALL drive line_start = 1 when hc = 0.
REQ-034 SHALL drive frame_start = 1 when hc = 0 and vc = 0, including the first pixel after reset.
REQ-035 SHALL require CW to hold H_TOT-1 and V_TOT-1; other parameter values are illegal and unchecked.

Reset
REQ-036 SHALL, while clr_n = 0 and immediately on its assertion (asynchronously, including mid-frame), force hc=0, vc=0, hsync=~HS_POL, vsync=~VS_POL, active=0, x=0, y=0, line_start=0, frame_start=0, frame_cnt=0.
REQ-037 SHALL present position (0,0) on the first pix_en edge after clr_n deasserts.

Configuration
REQ-038 SHALL, with macro VGA_TIMING_FRAMECNT_EN defined, increment frame_cnt (wrapping at 16 bits) on the pix_en edge where vc wraps V_TOT-1 to 0, coincident with the next frame_start; without the macro, frame_cnt SHALL be tied to 0 and no counter register SHALL exist.

Verification
REQ-039 SHALL cover: defaults, pix_en=1, release reset -> edge 1: hsync=0, vsync=0, line_start=1, frame_start=1, active=0; edge 97: hsync=1.
REQ-040 SHALL cover: defaults -> edge 24945: active=1, x=0, y=0; edge 25584: x=639; edge 25585: active=0, x=0.
REQ-041 SHALL cover: macro defined -> edge 416801: frame_start=1, frame_cnt=1; edge 833601: frame_cnt=2; without macro, frame_cnt=0 throughout.
REQ-042 SHALL cover: pix_en alternating 1/0 -> outputs change only on strobed edges; one frame spans 833600 dclk cycles.
REQ-043 SHALL cover: clr_n pulled low at hc=400, vc=200 between clock edges -> outputs reach reset values without waiting for a clock edge; after release, frame_start=1 on the first strobe.
REQ-044 SHALL cover: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> an 8-pixel line, a 6-line frame, hsync high for 2 pixels, x running 0..3.
